// File: rtl/convolutional_encoder_pkg.sv
// Shared 802.11a convolutional-code definitions: rates, generator taps, puncture masks, FSM states.
package convolutional_encoder_pkg;

  localparam int unsigned K_LEN = 7;
  localparam int unsigned S_W   = K_LEN - 1;
  localparam int unsigned PH_W  = 2;

  localparam logic [K_LEN-1:0] G0_TAPS = 7'o133;
  localparam logic [K_LEN-1:0] G1_TAPS = 7'o171;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_TAIL  = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  // One coded pair, also used as the per-bit keep mask.
  typedef struct packed {
    logic a;
    logic b;
  } pair_t;

  function automatic logic [PH_W-1:0] punct_period(rate_e r);
    case (r)
      RATE_2_3: punct_period = PH_W'(2);
      RATE_3_4: punct_period = PH_W'(3);
      default:  punct_period = PH_W'(1);
    endcase
  endfunction

  function automatic pair_t keep_mask(rate_e r, logic [PH_W-1:0] ph);
    keep_mask = '{a: 1'b1, b: 1'b1};
    case (r)
      RATE_2_3: if (ph != '0) keep_mask = '{a: 1'b1, b: 1'b0};
      RATE_3_4: begin
        if (ph == PH_W'(1)) keep_mask = '{a: 1'b1, b: 1'b0};
        else if (ph == PH_W'(2)) keep_mask = '{a: 1'b0, b: 1'b1};
      end
      default: keep_mask = '{a: 1'b1, b: 1'b1};
    endcase
  endfunction

  // Window MSB is the current bit, LSB the oldest delay, matching octal generator notation.
  function automatic pair_t encode(logic u, logic [S_W-1:0] s);
    logic [K_LEN-1:0] win;
    win = {u, s[0], s[1], s[2], s[3], s[4], s[5]};
    encode.a = ^(win & G0_TAPS);
    encode.b = ^(win & G1_TAPS);
  endfunction

endpackage

// File: rtl/convolutional_encoder_puncture_ctrl.sv
// Puncture phase counter and keep-mask lookup, shared with the receive-side depuncturer.
module puncture_ctrl
  import convolutional_encoder_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  advance,
  input  rate_e rate,
  output pair_t keep_c
);

  logic [PH_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (advance) begin
      phase_d = (phase_q == punct_period(rate) - PH_W'(1)) ? '0 : phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign keep_c = keep_mask(rate, phase_q);

endmodule

// File: rtl/convolutional_encoder.sv
// Rate-1/2 K=7 convolutional encoder with in-line puncturing to 2/3 and 3/4.
// Serial valid/ready in and out; optional internal zero-tail flush.
module convolutional_encoder
  import convolutional_encoder_pkg::*;
#(
  parameter int unsigned TAIL_BITS = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       Input,
  input  logic       InValid,
  input  logic       InLast,
  output logic       InReady,
  output logic       Output,
  output logic       OutValid,
  input  logic       OutReady,
  output logic       Done
);

  localparam int unsigned TC_W = (TAIL_BITS > 1) ? $clog2(TAIL_BITS) : 1;
  localparam logic [TC_W-1:0] TAIL_LAST = TC_W'((TAIL_BITS > 0) ? TAIL_BITS - 1 : 0);

  state_e          state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  rate_e           rate_q, rate_d;
  pair_t           pend_q, pend_d;
  pair_t           dat_q, dat_d;
  logic [TC_W-1:0] tail_q, tail_d;
  logic            out_bit_q, out_bit_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;

  pair_t pend_pop_c;
  pair_t code_c;
  pair_t keep_c;
  logic  space_c;
  logic  in_ready_c;
  logic  inject_c;
  logic  inj_bit_c;
  logic  ph_clear_c;

  puncture_ctrl u_puncture_ctrl (
    .clk     (Clock),
    .rst_n   (Reset),
    .clear   (ph_clear_c),
    .advance (inject_c),
    .rate    (rate_q),
    .keep_c  (keep_c)
  );

  // Pair buffer drain and room for the next encoded pair.
  always_comb begin
    pend_pop_c = pend_q;
    if (out_valid_q && OutReady) begin
      if (pend_q.a) pend_pop_c.a = 1'b0;
      else          pend_pop_c.b = 1'b0;
    end
    space_c    = (pend_q == '0) || ((pend_q.a ^ pend_q.b) && OutReady);
    in_ready_c = (state_q == ST_RUN) && space_c;
    inject_c   = ((state_q == ST_RUN) && InValid && in_ready_c) ||
                 ((state_q == ST_TAIL) && space_c);
    inj_bit_c  = (state_q == ST_RUN) ? Input : 1'b0;
    code_c     = encode(inj_bit_c, s_q);
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    rate_d     = rate_q;
    tail_d     = tail_q;
    dat_d      = dat_q;
    pend_d     = pend_pop_c;
    ph_clear_c = 1'b0;
    done_d     = 1'b0;

    if (inject_c) begin
      pend_d = keep_c;
      dat_d  = code_c;
      s_d    = {s_q[S_W-2:0], inj_bit_c};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d    = ST_RUN;
          s_d        = '0;
          rate_d     = rate_e'(Rate);
          tail_d     = '0;
          ph_clear_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (inject_c && InLast) state_d = (TAIL_BITS > 0) ? ST_TAIL : ST_FLUSH;
      end
      ST_TAIL: begin
        if (inject_c) begin
          if (tail_q == TAIL_LAST) state_d = ST_FLUSH;
          else                     tail_d  = tail_q + TC_W'(1);
        end
      end
      ST_FLUSH: begin
        // Done lands on the cycle right after the final handshake.
        if (pend_pop_c == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = |pend_d;
    out_bit_d   = pend_d.a ? dat_d.a : (pend_d.b & dat_d.b);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      rate_q      <= RATE_1_2;
      tail_q      <= '0;
      dat_q       <= '0;
      pend_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      rate_q      <= rate_d;
      tail_q      <= tail_d;
      dat_q       <= dat_d;
      pend_q      <= pend_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign InReady  = in_ready_c;
  assign Output   = out_bit_q;
  assign OutValid = out_valid_q;
  assign Done     = done_q;

endmodule
